telemetry_tx_arbiter: RTL and testbench

//  Shares the single AVR serial TX channel (tx_data/new_tx_data/tx_busy of avr_interface) between
//  NUM_SRC packet producers: debugging telemetry, flag/status reports, IMU state dumps, etc.

---
 rtl/telemetry_tx_arbiter_pkg.sv | 30 +++
 rtl/telemetry_tx_arbiter_chk.sv | 18 +
 rtl/telemetry_tx_arbiter_rr_arbiter.sv | 40 ++++
 rtl/telemetry_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_telemetry_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/telemetry_tx_arbiter_pkg.sv
// Shared definitions for the telemetry TX arbiter: FSM encoding, frame
// constants and small index helpers.
package telemetry_tx_arbiter_pkg;

    // Frame-level FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SRCID = 2'd2,
        ST_DATA  = 2'd3
    } tx_state_e;

    // First byte of every frame unless overridden at instantiation
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Cycles to wait after an issue so tx_busy from avr_interface is visible
    localparam logic [1:0] HOLD_CYC = 2'd2;

    // Round-robin successor of a source index, wrapping at num_src
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int num_src);
        logic [2:0] nxt;
        if (idx == 3'(num_src - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/telemetry_tx_arbiter_chk.sv
// Protocol checker for the TX side: a byte may only be strobed when the
// transmitter was idle and the post-issue hold had expired in the cycle
// the issue was decided.
module telemetry_tx_arbiter_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_busy,
    input  logic [1:0] hold,
    input  logic       new_tx_data
);

    // Strobe implies tx_ok in the previous cycle
    a_strobe_needs_tx_ok: assert property (
        @(posedge clk) disable iff (rst)
        new_tx_data |-> (!$past(tx_busy) && ($past(hold) == 2'd0))
    );

endmodule

// File: rtl/telemetry_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping at NUM_SRC. Returns one-hot grant, binary index and a valid flag.
module rr_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [2:0]         idx,
    output logic               any
);

    // Scan requesters starting at ptr and keep the first hit
    always_comb begin
        logic [3:0]         cand_s;
        logic [NUM_SRC-1:0] shifted_s;
        grant     = {NUM_SRC{1'b0}};
        idx       = 3'd0;
        any       = 1'b0;
        cand_s    = 4'd0;
        shifted_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = {1'b0, ptr} + 4'(i);
            if (cand_s >= 4'(NUM_SRC)) begin
                cand_s = cand_s - 4'(NUM_SRC);
            end else begin
                cand_s = cand_s;
            end
            shifted_s = req >> cand_s;
            if (!any && shifted_s[0]) begin
                any   = 1'b1;
                idx   = cand_s[2:0];
                grant = NUM_SRC'(1'b1) << cand_s;
            end else begin
                any   = any;
            end
        end
    end

endmodule

// File: rtl/telemetry_tx_arbiter.sv
// Shares the single AVR serial TX channel between NUM_SRC packet producers.
// Packet-granular round-robin; every frame is SYNC_BYTE, source id, payload.
// A producer that stalls inside its payload is aborted by a watchdog.
module telemetry_tx_arbiter
    import telemetry_tx_arbiter_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [NUM_SRC-1:0]     src_grant,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   tx_busy,
    output logic                   pkt_abort
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    tx_state_e          state_r, state_s;
    logic [2:0]         grant_idx_r, grant_idx_s;
    logic [NUM_SRC-1:0] grant_r, grant_s;
    logic [2:0]         rr_ptr_r, rr_ptr_s;
    logic [1:0]         hold_r, hold_s;
    logic [TW-1:0]      tout_r, tout_s;
    logic [7:0]         tx_data_r, tx_data_s;
    logic               new_tx_r, new_tx_s;
    logic               abort_r, abort_s;
    logic [NUM_SRC-1:0] ready_s;

    logic [NUM_SRC-1:0] arb_grant_s;
    logic [2:0]         arb_idx_s;
    logic               arb_any_s;

    logic               tx_ok_s;
    logic               valid_g_s;
    logic               last_g_s;
    logic [7:0]         data_g_s;
    logic [2:0]         next_ptr_s;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req   (src_req),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    telemetry_tx_arbiter_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .tx_busy     (tx_busy),
        .hold        (hold_r),
        .new_tx_data (new_tx_r)
    );

    assign tx_ok_s    = !tx_busy && (hold_r == 2'd0);
    assign valid_g_s  = |(src_valid & grant_r);
    assign last_g_s   = |(src_last & grant_r);
    assign next_ptr_s = wrap_inc(grant_idx_r, NUM_SRC);

    // Payload byte of the granted producer (one-hot AND-OR mux)
    always_comb begin
        data_g_s = 8'h00;
        for (int j = 0; j < NUM_SRC; j++) begin
            data_g_s = data_g_s | (src_data[j*8 +: 8] & {8{grant_r[j]}});
        end
    end

    // Next-state, issue and watchdog decisions for the frame FSM
    always_comb begin
        state_s     = state_r;
        grant_idx_s = grant_idx_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        hold_s      = (hold_r != 2'd0) ? (hold_r - 2'd1) : 2'd0;
        tout_s      = tout_r;
        tx_data_s   = tx_data_r;
        new_tx_s    = 1'b0;
        abort_s     = 1'b0;
        ready_s     = {NUM_SRC{1'b0}};
        case (state_r)
            ST_IDLE: begin
                tout_s = {TW{1'b0}};
                if (arb_any_s) begin
                    grant_s     = arb_grant_s;
                    grant_idx_s = arb_idx_s;
                    state_s     = ST_SYNC;
                end else begin
                    grant_s     = {NUM_SRC{1'b0}};
                end
            end
            ST_SYNC: begin
                if (tx_ok_s) begin
                    tx_data_s = SYNC_BYTE;
                    new_tx_s  = 1'b1;
                    hold_s    = HOLD_CYC;
                    state_s   = ST_SRCID;
                end else begin
                    state_s   = ST_SYNC;
                end
            end
            ST_SRCID: begin
                tout_s = {TW{1'b0}};
                if (tx_ok_s) begin
                    tx_data_s = {5'b00000, grant_idx_r};
                    new_tx_s  = 1'b1;
                    hold_s    = HOLD_CYC;
                    state_s   = ST_DATA;
                end else begin
                    state_s   = ST_SRCID;
                end
            end
            ST_DATA: begin
                ready_s = tx_ok_s ? grant_r : {NUM_SRC{1'b0}};
                if (tx_ok_s && valid_g_s) begin
                    // Accepted byte goes out on the next cycle
                    tx_data_s = data_g_s;
                    new_tx_s  = 1'b1;
                    hold_s    = HOLD_CYC;
                    tout_s    = {TW{1'b0}};
                    if (last_g_s) begin
                        state_s  = ST_IDLE;
                        grant_s  = {NUM_SRC{1'b0}};
                        rr_ptr_s = next_ptr_s;
                    end else begin
                        state_s  = ST_DATA;
                    end
                end else if (tx_ok_s) begin
                    // Channel free but producer silent: run the watchdog
                    if (tout_r == TW'(TIMEOUT_CYC - 1)) begin
                        abort_s  = 1'b1;
                        state_s  = ST_IDLE;
                        grant_s  = {NUM_SRC{1'b0}};
                        rr_ptr_s = next_ptr_s;
                        tout_s   = {TW{1'b0}};
                    end else begin
                        tout_s   = tout_r + TW'(1);
                    end
                end else begin
                    // Transmitter busy: stall is not the producer's fault
                    tout_s = tout_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {NUM_SRC{1'b0}};
            end
        endcase
    end

    // State and output registers, synchronous reset drops any frame silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= 3'd0;
            grant_r     <= {NUM_SRC{1'b0}};
            rr_ptr_r    <= 3'd0;
            hold_r      <= 2'd0;
            tout_r      <= {TW{1'b0}};
            tx_data_r   <= 8'h00;
            new_tx_r    <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_idx_r <= grant_idx_s;
            grant_r     <= grant_s;
            rr_ptr_r    <= rr_ptr_s;
            hold_r      <= hold_s;
            tout_r      <= tout_s;
            tx_data_r   <= tx_data_s;
            new_tx_r    <= new_tx_s;
            abort_r     <= abort_s;
        end
    end

    assign src_ready   = ready_s;
    assign src_grant   = grant_r;
    assign tx_data     = tx_data_r;
    assign new_tx_data = new_tx_r;
    assign pkt_abort   = abort_r;

endmodule

// File: tb/tb_telemetry_tx_arbiter.sv
// Bench for telemetry_tx_arbiter: producer models driven at negedge, an
// avr_interface busy model, and a scoreboard monitor for TX bytes and grants.
module tb_telemetry_tx_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int TOUT     = 20;
    localparam int BUSY_LEN = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_SRC-1:0]   src_req;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic [NUM_SRC-1:0]   src_grant;
    logic [7:0]           tx_data;
    logic                 new_tx_data;
    logic                 tx_busy;
    logic                 pkt_abort;
    logic                 force_busy = 1'b0;

    telemetry_tx_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .src_grant   (src_grant),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .pkt_abort   (pkt_abort)
    );

    always #5 clk = ~clk;

    // avr_interface model: busy for BUSY_LEN cycles after each strobe
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (new_tx_data) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    int checks = 0;
    int errors = 0;

    // scoreboard queues filled by stimulus
    int exp_q[$];
    int exp_g[$];

    // producer packet queues: bit 8 = last
    logic [8:0]         pq [NUM_SRC][$];
    logic [NUM_SRC-1:0] withhold = '0;

    // monitor-owned observations
    bit mon_en = 1'b0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = -100;
    int abort_cnt = 0;
    int abort_gap = -1;
    int ready_hi = 0;
    int req_seen_cyc = -1;
    int grant_seen_cyc = -1;
    int sync_lat = -1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Producers: change inputs at negedge, track acceptances seen at posedge
    initial begin
        logic [NUM_SRC-1:0] acc;
        logic [NUM_SRC-1:0] was_g;
        logic [8:0]         f;
        acc = '0; was_g = '0;
        src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rst) begin
                    pq[i].delete();
                end else begin
                    if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
                    if (pkt_abort && was_g[i]) pq[i].delete();
                end
                acc[i] = 1'b0;
                src_req[i] = (pq[i].size() != 0) && !src_grant[i];
                if (src_grant[i] && pq[i].size() != 0 && !withhold[i]) begin
                    f = pq[i][0];
                    src_valid[i] = 1'b1;
                    src_data[8*i +: 8] = f[7:0];
                    src_last[i] = f[8];
                end else if (!src_grant[i]) begin
                    src_valid[i] = 1'b1;          // noise the DUT must ignore
                    src_data[8*i +: 8] = 8'hEE;
                    src_last[i] = 1'b1;
                end else begin
                    src_valid[i] = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                    src_last[i] = 1'b0;
                end
                acc[i] = src_valid[i] && src_ready[i] && src_grant[i];
                was_g[i] = src_grant[i];
            end
        end
    end

    // Monitor: compare every strobe and grant against the scoreboard
    initial begin
        int e;
        int gi;
        bit busy_prev = 1'b0;
        bit need_first = 1'b0;
        logic [NUM_SRC-1:0] prev_grant = '0;
        logic [NUM_SRC-1:0] prev_req = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                cyc++;
                if (new_tx_data) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_byte: unexpected strobe 0x%0h, expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(tx_data) != e) begin
                            errors++;
                            $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", tx_data, e);
                        end
                    end
                    chk("busy_before_strobe", int'(busy_prev), 0);
                    checks++;
                    if (cyc - last_strobe_cyc < 3) begin
                        errors++;
                        $display("FAIL strobe_spacing: got %0d cycles, expected >= 3", cyc - last_strobe_cyc);
                    end
                    if (need_first) begin
                        sync_lat = cyc - grant_seen_cyc;
                        need_first = 1'b0;
                    end
                    last_strobe_cyc = cyc;
                    strobe_cnt++;
                end
                if (src_grant != '0 && prev_grant == '0) begin
                    gi = -1;
                    for (int k = 0; k < NUM_SRC; k++) if (src_grant[k]) gi = k;
                    checks++;
                    if (!$onehot(src_grant)) begin
                        errors++;
                        $display("FAIL grant_onehot: got %b, expected one-hot", src_grant);
                    end else if (exp_g.size() == 0) begin
                        errors++;
                        $display("FAIL grant_order: got src%0d, expected no grant", gi);
                    end else begin
                        e = exp_g.pop_front();
                        if (gi != e) begin
                            errors++;
                            $display("FAIL grant_order: got src%0d, expected src%0d", gi, e);
                        end
                    end
                    grant_seen_cyc = cyc;
                    need_first = 1'b1;
                end
                if (pkt_abort) begin
                    abort_cnt++;
                    abort_gap = cyc - last_strobe_cyc;
                end
                if (force_busy && src_ready != '0) ready_hi++;
                if (src_req != '0 && prev_req == '0) req_seen_cyc = cyc;
                busy_prev  = tx_busy;
                prev_grant = src_grant;
                prev_req   = src_req;
            end
        end
    end

    task automatic drain(input string nm, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
            done = (exp_q.size() == 0) && (exp_g.size() == 0) && (src_grant == '0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: got %0d bytes/%0d grants outstanding, expected 0", nm, exp_q.size(), exp_g.size());
            exp_q.delete();
            exp_g.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobes(input string nm, input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({"wait_", nm}, int'(strobe_cnt >= target), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int s, input int b0, input int n);
        for (int k = 0; k < n; k++) pq[s].push_back({(k == n - 1), 8'(b0 + 17 * k)});
    endtask

    initial begin
        int s0;
        int ab0;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // reset state
        chk("rst_grant", int'(src_grant), 0);
        chk("rst_ready", int'(src_ready), 0);
        chk("rst_new_tx", int'(new_tx_data), 0);
        chk("rst_abort", int'(pkt_abort), 0);
        chk("rst_tx_data", int'(tx_data), 0);

        // T1: single source, payload 11,22,33
        push_pkt(0, 8'h11, 3);
        exp_g.push_back(0);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        drain("single", 500);
        chk("req_to_grant", grant_seen_cyc - req_seen_cyc, 0);
        chk("grant_to_sync", sync_lat, 1);

        // T2: all four at once, src0 queues a second packet
        do_reset();
        pq[0].push_back({1'b1, 8'h40});
        pq[0].push_back({1'b1, 8'h44});
        pq[1].push_back({1'b1, 8'h41});
        pq[2].push_back({1'b1, 8'h42});
        pq[3].push_back({1'b1, 8'h43});
        exp_g = '{0, 1, 2, 3, 0};
        exp_q = '{8'hA5, 8'h00, 8'h40, 8'hA5, 8'h01, 8'h41, 8'hA5, 8'h02, 8'h42,
                  8'hA5, 8'h03, 8'h43, 8'hA5, 8'h00, 8'h44};
        drain("rr", 2000);

        // T3: src2 withholds valid, watchdog aborts, src3 next
        do_reset();
        ab0 = abort_cnt;
        withhold[2] = 1'b1;
        pq[2].push_back({1'b1, 8'h99});
        exp_g.push_back(2);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
        n = 0;
        while (!src_grant[2] && n < 100) begin @(posedge clk); #1; n++; end
        chk("t3_grant2", int'(src_grant[2]), 1);
        pq[3].push_back({1'b1, 8'h53});
        pq[1].push_back({1'b1, 8'h51});
        exp_g.push_back(3); exp_g.push_back(1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'h53);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h51);
        drain("timeout", 1000);
        withhold[2] = 1'b0;
        chk("abort_count", abort_cnt - ab0, 1);
        // srcid strobe, BUSY_LEN busy cycles, then TOUT silent cycles
        chk("abort_gap", abort_gap, 1 + BUSY_LEN + TOUT);

        // T4: tx_busy forced high for 100 cycles inside DATA
        do_reset();
        ab0 = abort_cnt;
        pq[1].push_back({1'b0, 8'h61});
        pq[1].push_back({1'b1, 8'h62});
        exp_g.push_back(1);
        exp_q = '{8'hA5, 8'h01, 8'h61, 8'h62};
        wait_strobes("t4_srcid", strobe_cnt + 2, 200);
        force_busy = 1'b1;
        s0 = strobe_cnt;
        ready_hi = 0;
        repeat (100) @(posedge clk);
        #1;
        chk("busy_no_strobe", strobe_cnt - s0, 0);
        chk("busy_no_ready", ready_hi, 0);
        force_busy = 1'b0;
        drain("busy", 500);
        chk("busy_no_abort", abort_cnt - ab0, 0);

        // T5: reset inside DATA, then a fresh frame
        do_reset();
        ab0 = abort_cnt;
        pq[3].push_back({1'b0, 8'h71});
        pq[3].push_back({1'b0, 8'h72});
        pq[3].push_back({1'b1, 8'h73});
        exp_g.push_back(3);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
        wait_strobes("t5_srcid", strobe_cnt + 2, 200);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_grant", int'(src_grant), 0);
        chk("mid_rst_ready", int'(src_ready), 0);
        chk("mid_rst_new_tx", int'(new_tx_data), 0);
        chk("mid_rst_abort", int'(pkt_abort), 0);
        chk("mid_rst_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_abort", abort_cnt - ab0, 0);
        chk("mid_rst_no_bytes", exp_q.size(), 0);
        pq[3].push_back({1'b1, 8'h81});
        exp_g.push_back(3);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'h81);
        drain("after_rst", 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
